btb_next_pc_predictor: RTL and testbench
========================================

// Module: btb_next_pc_predictor
// PURPOSE
// - Producer side of the next-PC selection path: drives the predicted next fetch address and the resolution redirect.
// - Direct-mapped branch target buffer (BTB) with a 2-bit saturating counter per entry. It is looked up in IF and updated from EX-stage branch/jump/jr resolution.
// - Drives NextPC straight into the PC register. On a wrong prediction it drives Mispredict so the pipeline flushes IF/ID.
// PARAMETERS
// - ENTRIES   16   number of BTB entries (power of two)
// - IDX_W     4    log2(ENTRIES)
// - ADDR_W    32   address width
// - CNT_W     16   width of the statistics counters
// PORTS
// - Clk            in   1       rising-edge clock (the only clock)
// - Rst_n          in   1       asynchronous, active-low reset
// - FetchPC        in   ADDR_W  PC of the instruction in IF
// - PCAdder        in   ADDR_W  FetchPC+4
// - Stall          in   1       IF stalled; suppresses LookupCount increment only
// - PredTaken      out  1       lookup hit and counter>=2'b10
// - PredTarget     out  ADDR_W  target stored in the hit entry (0 on miss)
// - NextPC         out  ADDR_W  next PC presented to the PC register
// - ResValid       in   1       resolved control-flow instruction valid in EX
// - ResPC          in   ADDR_W  PC of the resolved instruction
// - ResPCPlus4     in   ADDR_W  ResPC+4
// - ResTaken       in   1       actual outcome (jumps/jr always 1)
// - ResTarget      in   ADDR_W  actual target (branch/jump/jr address)
// - ResPredTaken   in   1       PredTaken carried down the pipe with the instruction
// - ResPredTarget  in   ADDR_W  PredTarget carried down the pipe with the instruction
// - Mispredict     out  1       flush IF/ID this cycle
// - RedirectPC     out  ADDR_W  correct PC after a misprediction
// - LookupCount    out  CNT_W   saturating count of non-stalled lookups
// - MispredCount   out  CNT_W   saturating count of mispredictions
// BEHAVIOUR
// - Index = PC[IDX_W+1:2]. Tag = PC[ADDR_W-1:IDX_W+2].
// - Entry state: Valid, Tag, Target, Ctr[1:0]. Reset values: Valid=0, Ctr=2'b01, Tag=0, Target=0.
// - Lookup is combinational, with 0-cycle latency: Hit = Valid[idx] & Tag match.
//   - PredTaken = Hit & Ctr[1].
//   - PredTarget = Hit ? Target : 0.
// - Mispredict (combinational) = ResValid & ((ResTaken != ResPredTaken) | (ResTaken & ResPredTaken & ResTarget != ResPredTarget)).
// - RedirectPC = ResTaken ? ResTarget : ResPCPlus4.
// - NextPC priority: Mispredict -> RedirectPC; else PredTaken -> PredTarget; else PCAdder.
// - Update is registered at the Clk edge when ResValid=1:
//   - Hit on ResPC: Ctr moves +1 if taken, -1 if not. It saturates at 2'b11 and 2'b00. Target is written with ResTarget when taken.
//   - Miss and taken: allocate (overwrite) the entry. Valid=1, Tag, Target=ResTarget, Ctr=2'b10.
//   - Miss and not taken: no state change.
// - Same-index lookup and update in the same cycle: the lookup sees pre-update contents. There is no bypass.
// - Statistics counters:
//   - LookupCount increments when Stall=0.
//   - MispredCount increments when Mispredict=1.
//   - Both saturate at all-ones and never wrap.
// - Reset (async, any time, including mid-update): all entries go to the reset values above and both counters clear to 0.
//   - During reset PredTaken=0 and PredTarget=0.
//   - NextPC = PCAdder unless Mispredict=1.
//   - Mispredict and RedirectPC stay purely combinational from the Res* inputs.
// - Stall does not block updates or Mispredict; the redirect always wins.
// STRUCTURE
// - Package mips_btb_pkg holds:
//   - counter encodings (STRONG_NT=2'b00, WEAK_NT=2'b01, WEAK_T=2'b10, STRONG_T=2'b11)
//   - the ctr_next(ctr, taken) saturating function
//   - the btb_entry_t struct {valid, tag, target, ctr}
// - One sub-module, btb_entry_array: ENTRIES-deep storage with async clear, one combinational read port (lookup) and one combinational read + synchronous write port (update).
// - Top level: NextPC mux, mispredict compare and statistics counters.
// TESTING
// - Reset, then FetchPC=0x00400000 -> PredTaken=0, NextPC=0x00400004, both counters 0.
// - Resolve ResPC=0x00400010 taken, target 0x00400100, ResPredTaken=0 -> Mispredict=1, RedirectPC=0x00400100; next fetch of 0x00400010 -> PredTaken=1, NextPC=0x00400100.
// - Same entry resolved not-taken twice -> Ctr 10->01->00; the first resolution gives Mispredict=1 and RedirectPC=0x00400014; PredTaken=0 afterwards.
// - Alias: ResPC=0x00800010 taken, target 0x00800200 -> overwrites index 4; lookup of 0x00400010 now misses.
// - Hit with stale target: ResPredTaken=1, ResPredTarget=0x00400100, ResTarget=0x00400300 -> Mispredict=1, entry target becomes 0x00400300.
// - Force MispredCount to 0xFFFF, then mispredict again -> stays 0xFFFF; assert Rst_n=0 mid-cycle -> PredTaken drops to 0 immediately.

Source files
------------

// File: rtl/mips_btb_pkg.sv
// Shared types, widths and the saturating counter rule for the BTB next-PC predictor.
package mips_btb_pkg;

    localparam int ENTRIES = 16;
    localparam int IDX_W   = 4;
    localparam int ADDR_W  = 32;
    localparam int CNT_W   = 16;
    localparam int TAG_W   = ADDR_W - IDX_W - 2;

    typedef enum logic [1:0] {
        STRONG_NT = 2'b00,
        WEAK_NT   = 2'b01,
        WEAK_T    = 2'b10,
        STRONG_T  = 2'b11
    } ctr_t;

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [ADDR_W-1:0] target;
        ctr_t              ctr;
    } btb_entry_t;

    localparam btb_entry_t RESET_ENTRY = '{valid: 1'b0, tag: '0, target: '0, ctr: WEAK_NT};

    // Two-bit saturating step: taken moves toward STRONG_T, not-taken toward STRONG_NT.
    function automatic ctr_t ctr_next(input ctr_t ctr, input logic taken);
        ctr_t result;
        result = ctr;
        case (ctr)
            STRONG_NT: result = taken ? WEAK_NT  : STRONG_NT;
            WEAK_NT:   result = taken ? WEAK_T   : STRONG_NT;
            WEAK_T:    result = taken ? STRONG_T : WEAK_NT;
            STRONG_T:  result = taken ? STRONG_T : WEAK_T;
            default:   result = WEAK_NT;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/btb_entry_array.sv
// Direct-mapped BTB storage: async clear, one lookup read port and one read/write update port.
module btb_entry_array
    import mips_btb_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] lookup_idx,
    output btb_entry_t       lookup_entry,
    input  logic [IDX_W-1:0] upd_idx,
    output btb_entry_t       upd_entry,
    input  logic             wr_en,
    input  btb_entry_t       wr_entry
);

    btb_entry_t entries [ENTRIES];

    assign lookup_entry = entries[lookup_idx];
    assign upd_entry    = entries[upd_idx];

    // Clear every entry on reset; otherwise write the resolved entry at the clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                entries[i] <= RESET_ENTRY;
            end
        end else if (wr_en) begin
            entries[upd_idx] <= wr_entry;
        end
    end

endmodule

// File: rtl/btb_next_pc_predictor.sv
// Next-PC selection: BTB lookup in IF, resolution compare and update from EX, statistics.
module btb_next_pc_predictor
    import mips_btb_pkg::*;
(
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic [ADDR_W-1:0] FetchPC,
    input  logic [ADDR_W-1:0] PCAdder,
    input  logic              Stall,
    output logic              PredTaken,
    output logic [ADDR_W-1:0] PredTarget,
    output logic [ADDR_W-1:0] NextPC,
    input  logic              ResValid,
    input  logic [ADDR_W-1:0] ResPC,
    input  logic [ADDR_W-1:0] ResPCPlus4,
    input  logic              ResTaken,
    input  logic [ADDR_W-1:0] ResTarget,
    input  logic              ResPredTaken,
    input  logic [ADDR_W-1:0] ResPredTarget,
    output logic              Mispredict,
    output logic [ADDR_W-1:0] RedirectPC,
    output logic [CNT_W-1:0]  LookupCount,
    output logic [CNT_W-1:0]  MispredCount
);

    logic [IDX_W-1:0] lookup_idx;
    logic [TAG_W-1:0] lookup_tag;
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    btb_entry_t       lookup_entry;
    btb_entry_t       upd_entry;
    btb_entry_t       wr_entry;
    logic             wr_en;
    logic             lookup_hit;
    logic             upd_hit;

    assign lookup_idx = FetchPC[IDX_W+1:2];
    assign lookup_tag = FetchPC[ADDR_W-1:IDX_W+2];
    assign upd_idx    = ResPC[IDX_W+1:2];
    assign upd_tag    = ResPC[ADDR_W-1:IDX_W+2];

    btb_entry_array u_array (
        .clk          (Clk),
        .rst_n        (Rst_n),
        .lookup_idx   (lookup_idx),
        .lookup_entry (lookup_entry),
        .upd_idx      (upd_idx),
        .upd_entry    (upd_entry),
        .wr_en        (wr_en),
        .wr_entry     (wr_entry)
    );

    // Lookup sees pre-update contents; a cleared array during reset forces a miss.
    always_comb begin
        lookup_hit = lookup_entry.valid && (lookup_entry.tag == lookup_tag);
        PredTaken  = lookup_hit && lookup_entry.ctr[1];
        PredTarget = lookup_hit ? lookup_entry.target : '0;
    end

    // Resolution compare, redirect target and the next-PC priority mux.
    always_comb begin
        Mispredict = ResValid && ((ResTaken != ResPredTaken) ||
                                  (ResTaken && ResPredTaken && (ResTarget != ResPredTarget)));
        RedirectPC = ResTaken ? ResTarget : ResPCPlus4;
        if (Mispredict) begin
            NextPC = RedirectPC;
        end else if (PredTaken) begin
            NextPC = PredTarget;
        end else begin
            NextPC = PCAdder;
        end
    end

    // Build the entry to write: train a hit, allocate on a taken miss, ignore a not-taken miss.
    always_comb begin
        upd_hit  = upd_entry.valid && (upd_entry.tag == upd_tag);
        wr_en    = ResValid && (upd_hit || ResTaken);
        wr_entry = upd_entry;
        if (upd_hit) begin
            wr_entry.ctr = ctr_next(upd_entry.ctr, ResTaken);
            if (ResTaken) begin
                wr_entry.target = ResTarget;
            end
        end else begin
            wr_entry.valid  = 1'b1;
            wr_entry.tag    = upd_tag;
            wr_entry.target = ResTarget;
            wr_entry.ctr    = WEAK_T;
        end
    end

    // Saturating statistics counters.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            LookupCount  <= '0;
            MispredCount <= '0;
        end else begin
            if (!Stall && (LookupCount != '1)) begin
                LookupCount <= LookupCount + 1'b1;
            end
            if (Mispredict && (MispredCount != '1)) begin
                MispredCount <= MispredCount + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_btb_next_pc_predictor.sv
// Self-checking bench for btb_next_pc_predictor: reset-time vector table, directed sequences,
// randomized traffic against an array-based reference model, counter saturation and async reset.
module tb_btb_next_pc_predictor;

    logic        Clk;
    logic        Rst_n;
    logic [31:0] FetchPC;
    logic [31:0] PCAdder;
    logic        Stall;
    logic        PredTaken;
    logic [31:0] PredTarget;
    logic [31:0] NextPC;
    logic        ResValid;
    logic [31:0] ResPC;
    logic [31:0] ResPCPlus4;
    logic        ResTaken;
    logic [31:0] ResTarget;
    logic        ResPredTaken;
    logic [31:0] ResPredTarget;
    logic        Mispredict;
    logic [31:0] RedirectPC;
    logic [15:0] LookupCount;
    logic [15:0] MispredCount;

    btb_next_pc_predictor dut (
        .Clk           (Clk),
        .Rst_n         (Rst_n),
        .FetchPC       (FetchPC),
        .PCAdder       (PCAdder),
        .Stall         (Stall),
        .PredTaken     (PredTaken),
        .PredTarget    (PredTarget),
        .NextPC        (NextPC),
        .ResValid      (ResValid),
        .ResPC         (ResPC),
        .ResPCPlus4    (ResPCPlus4),
        .ResTaken      (ResTaken),
        .ResTarget     (ResTarget),
        .ResPredTaken  (ResPredTaken),
        .ResPredTarget (ResPredTarget),
        .Mispredict    (Mispredict),
        .RedirectPC    (RedirectPC),
        .LookupCount   (LookupCount),
        .MispredCount  (MispredCount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    // Reference model: plain arrays of entry fields and integer counters.
    bit          m_valid  [16];
    int unsigned m_tag    [16];
    int unsigned m_target [16];
    int          m_ctr    [16];
    int unsigned m_lookups;
    int unsigned m_mispreds;

    logic        exp_pt;
    logic [31:0] exp_ptgt;
    logic        exp_mis;
    logic [31:0] exp_red;
    logic [31:0] exp_next;

    typedef struct {
        logic        rv;
        logic        rt;
        logic        rpt;
        logic [31:0] rtgt;
        logic [31:0] rptgt;
        logic        e_mis;
        logic [31:0] e_red;
        logic [31:0] e_next;
    } vec_t;

    vec_t vecs [7];

    function automatic int unsigned idxOf(input logic [31:0] pc);
        return int'(pc[5:2]);
    endfunction

    function automatic int unsigned tagOf(input logic [31:0] pc);
        return int'(pc >> 6);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i]  = 1'b0;
            m_tag[i]    = 0;
            m_target[i] = 0;
            m_ctr[i]    = 1;
        end
        m_lookups  = 0;
        m_mispreds = 0;
    endtask

    task automatic modelExpect();
        int unsigned i;
        bit hit;
        i        = idxOf(FetchPC);
        hit      = m_valid[i] && (m_tag[i] == tagOf(FetchPC));
        exp_pt   = hit && (m_ctr[i] >= 2);
        exp_ptgt = hit ? m_target[i] : 32'h0;
        if (!ResValid) begin
            exp_mis = 1'b0;
        end else if (ResTaken != ResPredTaken) begin
            exp_mis = 1'b1;
        end else begin
            exp_mis = ResTaken && (ResTarget != ResPredTarget);
        end
        exp_red  = ResTaken ? ResTarget : ResPC + 32'd4;
        exp_next = exp_mis ? exp_red : (exp_pt ? exp_ptgt : FetchPC + 32'd4);
    endtask

    task automatic modelClock();
        int unsigned i;
        modelExpect();
        if (!Stall && m_lookups < 65535) m_lookups++;
        if (exp_mis && m_mispreds < 65535) m_mispreds++;
        if (ResValid) begin
            i = idxOf(ResPC);
            if (m_valid[i] && m_tag[i] == tagOf(ResPC)) begin
                if (ResTaken) begin
                    m_ctr[i]    = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
                    m_target[i] = ResTarget;
                end else begin
                    m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
                end
            end else if (ResTaken) begin
                m_valid[i]  = 1'b1;
                m_tag[i]    = tagOf(ResPC);
                m_target[i] = ResTarget;
                m_ctr[i]    = 2;
            end
        end
    endtask

    task automatic applyStimulus(input logic [31:0] fetch, input logic stall, input logic rv,
                                 input logic [31:0] rpc, input logic rt, input logic [31:0] rtgt,
                                 input logic rpt, input logic [31:0] rptgt);
        FetchPC       = fetch;
        PCAdder       = fetch + 32'd4;
        Stall         = stall;
        ResValid      = rv;
        ResPC         = rpc;
        ResPCPlus4    = rpc + 32'd4;
        ResTaken      = rt;
        ResTarget     = rtgt;
        ResPredTaken  = rpt;
        ResPredTarget = rptgt;
    endtask

    task automatic sampleCheck(input string name);
        @(negedge Clk);
        modelExpect();
        checkOutput({name, ".PredTaken"},    {31'b0, PredTaken},  {31'b0, exp_pt});
        checkOutput({name, ".PredTarget"},   PredTarget,          exp_ptgt);
        checkOutput({name, ".Mispredict"},   {31'b0, Mispredict}, {31'b0, exp_mis});
        checkOutput({name, ".RedirectPC"},   RedirectPC,          exp_red);
        checkOutput({name, ".NextPC"},       NextPC,              exp_next);
        checkOutput({name, ".LookupCount"},  {16'b0, LookupCount},  m_lookups);
        checkOutput({name, ".MispredCount"}, {16'b0, MispredCount}, m_mispreds);
    endtask

    task automatic advance();
        modelClock();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        logic [31:0] rpc;
        logic [31:0] fpc;

        vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h00402000, 32'h00402000, 1'b0, 32'h00401004, 32'h00400004};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 32'h00402000, 32'h00000000, 1'b1, 32'h00402000, 32'h00402000};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 32'h00402000, 32'h00402000, 1'b1, 32'h00401004, 32'h00401004};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 32'h00402000, 32'h00402000, 1'b0, 32'h00402000, 32'h00400004};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 32'h00402000, 32'h00403000, 1'b1, 32'h00402000, 32'h00402000};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 32'h00402000, 32'h00000000, 1'b0, 32'h00402000, 32'h00400004};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 32'h00402000, 32'h00405000, 1'b0, 32'h00401004, 32'h00400004};

        modelReset();
        Rst_n = 1'b0;
        applyStimulus(32'h00400000, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);

        // Resolution path is combinational even while reset holds the array clear.
        for (int v = 0; v < 7; v++) begin
            applyStimulus(32'h00400000, 1'b0, vecs[v].rv, 32'h00401000, vecs[v].rt,
                          vecs[v].rtgt, vecs[v].rpt, vecs[v].rptgt);
            @(negedge Clk);
            checkOutput($sformatf("vec%0d.Mispredict", v), {31'b0, Mispredict}, {31'b0, vecs[v].e_mis});
            checkOutput($sformatf("vec%0d.RedirectPC", v), RedirectPC, vecs[v].e_red);
            checkOutput($sformatf("vec%0d.NextPC", v), NextPC, vecs[v].e_next);
            checkOutput($sformatf("vec%0d.PredTaken", v), {31'b0, PredTaken}, 32'h0);
        end

        applyStimulus(32'h00400000, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        @(posedge Clk);
        #1;
        Rst_n = 1'b1;

        // Post-reset lookup.
        sampleCheck("reset");
        checkOutput("reset.NextPC_const", NextPC, 32'h00400004);
        checkOutput("reset.LookupCount_const", {16'b0, LookupCount}, 32'h0);
        advance();

        // Taken miss allocates; mispredict to the target.
        applyStimulus(32'h00400000, 1'b0, 1'b1, 32'h00400010, 1'b1, 32'h00400100, 1'b0, 32'h0);
        sampleCheck("alloc");
        checkOutput("alloc.Redirect_const", RedirectPC, 32'h00400100);
        advance();
        applyStimulus(32'h00400010, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        sampleCheck("hit");
        checkOutput("hit.NextPC_const", NextPC, 32'h00400100);
        advance();

        // Two not-taken resolutions walk the counter 10 -> 01 -> 00.
        applyStimulus(32'h00400000, 1'b0, 1'b1, 32'h00400010, 1'b0, 32'h0, 1'b1, 32'h00400100);
        sampleCheck("nt1");
        checkOutput("nt1.Redirect_const", RedirectPC, 32'h00400014);
        advance();
        applyStimulus(32'h00400010, 1'b0, 1'b1, 32'h00400010, 1'b0, 32'h0, 1'b0, 32'h0);
        sampleCheck("nt2");
        checkOutput("nt2.PredTaken_const", {31'b0, PredTaken}, 32'h0);
        advance();
        applyStimulus(32'h00400010, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        sampleCheck("nt_after");
        advance();

        // Alias at index 4 overwrites; same-cycle lookup still sees the old entry.
        applyStimulus(32'h00400010, 1'b0, 1'b1, 32'h00800010, 1'b1, 32'h00800200, 1'b0, 32'h0);
        sampleCheck("alias");
        checkOutput("alias.PredTarget_old", PredTarget, 32'h00400100);
        advance();
        applyStimulus(32'h00400010, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        sampleCheck("alias_miss");
        checkOutput("alias_miss.PredTarget", PredTarget, 32'h0);
        advance();
        applyStimulus(32'h00800010, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        sampleCheck("alias_hit");
        checkOutput("alias_hit.NextPC", NextPC, 32'h00800200);
        advance();

        // Stale target on a predicted-taken hit.
        applyStimulus(32'h00400000, 1'b0, 1'b1, 32'h00400010, 1'b1, 32'h00400100, 1'b0, 32'h0);
        sampleCheck("realloc");
        advance();
        applyStimulus(32'h00400000, 1'b0, 1'b1, 32'h00400010, 1'b1, 32'h00400300, 1'b1, 32'h00400100);
        sampleCheck("stale");
        checkOutput("stale.Redirect_const", RedirectPC, 32'h00400300);
        advance();
        applyStimulus(32'h00400010, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        sampleCheck("stale_after");
        checkOutput("stale_after.PredTarget", PredTarget, 32'h00400300);
        advance();

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            fpc = (($urandom % 2) != 0 ? 32'h00800000 : 32'h00400000) | (($urandom % 16) << 2);
            rpc = (($urandom % 2) != 0 ? 32'h00800000 : 32'h00400000) | (($urandom % 16) << 2);
            applyStimulus(fpc, ($urandom % 4) == 0, ($urandom % 2) != 0, rpc, ($urandom % 2) != 0,
                          32'h00400000 | (($urandom % 256) << 2), ($urandom % 2) != 0,
                          ($urandom % 2) != 0 ? m_target[idxOf(rpc)] : 32'h00400000 | (($urandom % 256) << 2));
            sampleCheck("rand");
            advance();
        end

        // Saturate both counters with mispredicts on a never-allocated tag.
        applyStimulus(32'h00400000, 1'b0, 1'b1, 32'h00700000, 1'b0, 32'h0, 1'b1, 32'h0);
        for (int n = 0; n < 66000; n++) begin
            advance();
        end
        sampleCheck("sat");
        checkOutput("sat.MispredCount_const", {16'b0, MispredCount}, 32'h0000FFFF);
        checkOutput("sat.LookupCount_const", {16'b0, LookupCount}, 32'h0000FFFF);
        advance();

        // Train 0x00400010 taken, then drop reset mid-cycle while it is predicted taken.
        applyStimulus(32'h00400000, 1'b0, 1'b1, 32'h00400010, 1'b1, 32'h00400100, 1'b0, 32'h0);
        advance();
        advance();
        applyStimulus(32'h00400010, 1'b0, 1'b1, 32'h00400010, 1'b1, 32'h00400100, 1'b1, 32'h00400100);
        sampleCheck("pre_reset");
        checkOutput("pre_reset.PredTaken", {31'b0, PredTaken}, 32'h1);
        #2;
        Rst_n = 1'b0;
        #1;
        modelReset();
        modelExpect();
        checkOutput("async.PredTaken", {31'b0, PredTaken}, 32'h0);
        checkOutput("async.PredTarget", PredTarget, 32'h0);
        checkOutput("async.NextPC", NextPC, exp_next);
        checkOutput("async.NextPC_const", NextPC, 32'h00400014);
        checkOutput("async.MispredCount", {16'b0, MispredCount}, 32'h0);
        checkOutput("async.LookupCount", {16'b0, LookupCount}, 32'h0);
        @(posedge Clk);
        #1;
        Rst_n = 1'b1;
        applyStimulus(32'h00400010, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        sampleCheck("post_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
